// File: rtl/aes_enc_key_sched.sv
// AES-128 encryption key schedule.
// Expands a 128-bit cipher key into 11 round keys, one round per clock.
// The round keys are held in a register store with a registered read port.
// round_key_10 is brought out separately to seed an inverse (decrypt) schedule.
module aes_enc_key_sched (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] cipher_key,
   input  logic         key_start,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_rd_addr,
   output logic         key_busy,
   output logic         key_done,
   output logic         key_valid,
   output logic [3:0]   round_num,
   output logic [127:0] round_key_10,
   output logic [127:0] rk_rd_data
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_EXPAND = 1'b1;

   // S-box table, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [0:0]   r_state;
   logic [127:0] r_rk [0:10];
   logic [127:0] r_rd_data;
   logic [3:0]   r_round;
   logic         r_busy;
   logic         r_done;
   logic         r_valid;

   logic [127:0] w_prev;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [7:0]   w_rcon;
   logic [31:0]  w_t;
   logic [127:0] w_next;

   // Select rk[round_num-1], the source of the round being computed.
   always_comb begin
      w_prev = '0;
      for (int i = 0; i < 10; i++) begin
         if (r_round == 4'(i + 1)) begin
            w_prev = r_rk[i];
         end
      end
   end

   assign w_rot = {w_prev[23:0], w_prev[31:24]};

   // One S-box lookup per byte of the rotated last word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         assign w_sub[gi*8 +: 8] = SBOX[11'd2047 - {w_rot[gi*8 +: 8], 3'b000} -: 8];
      end
   endgenerate

   // Round constant for the round being written.
   always_comb begin
      case (r_round)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_t = w_sub ^ {w_rcon, 24'h0};
   assign w_next[127:96] = w_prev[127:96] ^ w_t;
   assign w_next[95:64]  = w_prev[95:64]  ^ w_next[127:96];
   assign w_next[63:32]  = w_prev[63:32]  ^ w_next[95:64];
   assign w_next[31:0]   = w_prev[31:0]   ^ w_next[63:32];

   // Control FSM and round-key store; reset wins over a start on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_round <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         for (int i = 0; i < 11; i++) begin
            r_rk[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (key_start) begin
                  r_rk[0] <= cipher_key;
                  r_round <= 4'd1;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b0;
                  r_state <= ST_EXPAND;
               end
            end
            default: begin
               // key_start is deliberately ignored here.
               for (int i = 1; i < 11; i++) begin
                  if (r_round == 4'(i)) begin
                     r_rk[i] <= w_next;
                  end
               end
               if (r_round == 4'd10) begin
                  r_round <= 4'd0;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_round <= r_round + 4'd1;
               end
            end
         endcase
      end
   end

   // Registered read port; sees the store value from before this edge's write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (rk_rd_en) begin
         r_rd_data <= '0;
         for (int i = 0; i < 11; i++) begin
            if (rk_rd_addr == 4'(i)) begin
               r_rd_data <= r_rk[i];
            end
         end
      end
   end

   assign key_busy     = r_busy;
   assign key_done     = r_done;
   assign key_valid    = r_valid;
   assign round_num    = r_round;
   assign round_key_10 = r_rk[10];
   assign rk_rd_data   = r_rd_data;

endmodule
